i2c_subordinate: RTL and testbench
==================================

Name: i2c_subordinate

Overview:
- Synthesizable I2C subordinate (target) endpoint. It sits on the far side of the SCL/SDA bus driven by I2C_master and replaces the behavioural subordinate model used in system benches.
- Oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address and ACKs it.
- On writes, delivers received bytes to local logic; on reads, fetches bytes from local logic and shifts them out.
- SDA is open-drain: the block only ever pulls low.

Parameters:
- DEV_ADDR, 7'h01, own 7-bit bus address.
- SDA_HOLD, 4, clk cycles between a detected SCL falling edge and any sda_oe change (tHD;DAT).

Ports:
- clk  in  1  system clock; must be at least 16x SCL rate (100 MHz vs 400 kHz).
- rst_n  in  1  reset, asynchronous assert, active-low.
- scl_in  in  1  bus SCL, asynchronous.
- sda_in  in  1  bus SDA, asynchronous.
- sda_oe  out  1  1 = pull SDA low; 0 = release. Top level: SDA = sda_oe ? 0 : z.
- rx_data  out  8  last byte written by master.
- rx_valid  out  1  one-cycle pulse; rx_data valid.
- rx_ready  in  1  sampled at the 8th data SCL rise; 0 = NACK that byte.
- tx_req  out  1  one-cycle pulse; local logic must present the next read byte.
- tx_data  in  8  read byte; latched at the first SCL fall after tx_req.
- addressed  out  1  high from address ACK until STOP/START/NACK-end.
- busy  out  1  high between START and STOP.

Behaviour:
- Reset values: sda_oe=0, rx_data=0, rx_valid=0, tx_req=0, addressed=0, busy=0, state=IDLE, bit_cnt=7.
- Input path: 2-FF synchronizer per line plus a delayed copy for edge detect. All edges are seen 3 clk after the pin changes.
- START = SDA fall while SCL high. STOP = SDA rise while SCL high. These override every state.
- Data is sampled on SCL rise. sda_oe changes only SDA_HOLD clk after a SCL fall.
- States: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP.
  - IDLE: on START go to ADDR, busy=1, bit_cnt=7.
  - ADDR: shift 8 bits MSB first (7 address + R/W). After the 8th rise:
    - match → ADDR_ACK;
    - mismatch → WAIT_STOP (sda_oe stays 0).
  - ADDR_ACK: pull SDA low from the SCL fall after bit 8 through the next SCL fall, then:
    - rw=0 → WRITE;
    - rw=1 → READ.
    - Set addressed=1.
    - For rw=1, pulse tx_req on the ACK SCL rise.
  - WRITE: shift 8 bits. On the 8th rise:
    - update rx_data, pulse rx_valid (same cycle);
    - sample rx_ready; go to WRITE_ACK.
  - WRITE_ACK: pull low for one SCL period if rx_ready=1, else release; then WRITE.
  - READ:
    - At the SCL fall that opens the byte, latch tx_data into the shift register.
    - Drive bit 7 at +SDA_HOLD. A 1 bit releases (sda_oe=0); a 0 bit pulls low (sda_oe=1).
    - Advance on each fall; after the 8th bit's fall, release SDA and go to READ_ACK.
  - READ_ACK: sample master ACK on SCL rise.
    - SDA=0 → pulse tx_req, go to READ.
    - SDA=1 (NACK) → WAIT_STOP, addressed=0.
  - WAIT_STOP: sda_oe=0 until START (→ ADDR) or STOP (→ IDLE).
- Repeated START mid-transfer: abort the byte, release SDA at once (no hold delay), go to ADDR. No rx_valid for the partial byte.
- STOP mid-byte: discard the partial byte, go to IDLE; busy=0 and addressed=0 next cycle.
- Async reset mid-operation releases SDA immediately.
- bit_cnt is 3 bits, counts down 7→0 and wraps back to 7 at each new byte.
- rx_valid and tx_req never assert in the same cycle.

Decomposition:
- Package i2c_pkg:
  - typedef enum logic [2:0] sub_state_t;
  - constants I2C_READ=1'b1, I2C_WRITE=1'b0, ACK=1'b0, NACK=1'b1.
- Sub-module i2c_bus_sync: synchronizers, edge detect, START/STOP flags. Reusable by the master.

Test Plan:
- Write 0xAB to 0x01, rx_ready=1 → address ACK low; one rx_valid with rx_data=0xAB; data ACK low; busy falls within 4 clk of STOP.
- Read from 0x01, tx_data=0xC3, master NACK → one tx_req; bus shows bits 1,1,0,0,0,0,1,1; addressed drops after NACK; sda_oe=0 during the master ACK slot.
- Address 0x02 write → sda_oe never asserts; master reports ack_error; no rx_valid; IDLE after STOP.
- Read 3 bytes 0x11,0x22,0x33, master ACK,ACK,NACK → exactly 3 tx_req pulses; bytes match in order.
- Write 0x5A with rx_ready=0 → rx_valid pulses with 0x5A; data-ACK slot released (NACK seen by master).
- STOP after 4 data bits, then repeated START with address 0x01 read; separately, rst_n low mid-byte → no rx_valid, clean re-address; sda_oe=0 within 1 clk of rst_n low.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and bus constants for the I2C subordinate endpoint.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WRITE,
    ST_WRITE_ACK,
    ST_READ,
    ST_READ_ACK,
    ST_WAIT_STOP
  } sub_state_t;

  localparam logic I2C_READ  = 1'b1;
  localparam logic I2C_WRITE = 1'b0;
  localparam logic ACK       = 1'b0;
  localparam logic NACK      = 1'b1;

endpackage

// File: rtl/i2c_subordinate_if.sv
// Bus pins plus local byte handshake of the I2C subordinate.
interface i2c_subordinate_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       addressed;
  logic       busy;

  modport slave (
    input  scl_in, sda_in, rx_ready, tx_data,
    output sda_oe, rx_data, rx_valid, tx_req, addressed, busy
  );

  modport master (
    output scl_in, sda_in, rx_ready, tx_data,
    input  sda_oe, rx_data, rx_valid, tx_req, addressed, busy
  );
endinterface

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers with edge and START/STOP detection.
// Flags are valid one cycle, three clocks after the pin change.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_val,
  output logic start_det,
  output logic stop_det
);

  logic scl_meta_q, scl_sync_q, scl_dly_q;
  logic sda_meta_q, sda_sync_q, sda_dly_q;

  // Two-stage synchronizer plus one delayed copy per line; idle bus is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_dly_q  <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_dly_q  <= 1'b1;
    end else begin
      scl_meta_q <= scl_in;
      scl_sync_q <= scl_meta_q;
      scl_dly_q  <= scl_sync_q;
      sda_meta_q <= sda_in;
      sda_sync_q <= sda_meta_q;
      sda_dly_q  <= sda_sync_q;
    end
  end

  assign scl_rise  = scl_sync_q & ~scl_dly_q;
  assign scl_fall  = ~scl_sync_q & scl_dly_q;
  assign sda_val   = sda_sync_q;
  assign start_det = scl_sync_q & scl_dly_q & ~sda_sync_q & sda_dly_q;
  assign stop_det  = scl_sync_q & scl_dly_q & sda_sync_q & ~sda_dly_q;

endmodule

// File: rtl/i2c_subordinate.sv
// I2C subordinate endpoint: address match/ACK, byte receive and transmit.
module i2c_subordinate
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = 7'h01,
  parameter int unsigned SDA_HOLD = 4
) (
  input logic             clk,
  input logic             rst_n,
  i2c_subordinate_if.slave bus
);

  localparam int unsigned HW = $clog2(SDA_HOLD + 1);

  logic scl_rise, scl_fall, sda_val, start_det, stop_det;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_in    (bus.scl_in),
    .sda_in    (bus.sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .sda_val   (sda_val),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  sub_state_t    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          rw_q, rw_d;
  logic          ack_open_q, ack_open_d;
  logic          load_q, load_d;
  logic          rdy_q, rdy_d;
  logic          pend_q, pend_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          sda_oe_q, sda_oe_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          tx_req_q, tx_req_d;
  logic          addressed_q, addressed_d;
  logic          busy_q, busy_d;
  logic          sched, sched_val;

  // Next-state logic; SDA changes are scheduled at an SCL fall and applied
  // SDA_HOLD cycles later, except START/STOP which release SDA at once.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    rw_d        = rw_q;
    ack_open_d  = ack_open_q;
    load_d      = load_q;
    rdy_d       = rdy_q;
    pend_d      = pend_q;
    hold_d      = hold_q;
    sda_oe_d    = sda_oe_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_req_d    = 1'b0;
    addressed_d = addressed_q;
    busy_d      = busy_q;
    sched       = 1'b0;
    sched_val   = 1'b0;

    if (hold_q != '0) begin
      hold_d = hold_q - HW'(1);
      if (hold_q == HW'(1)) sda_oe_d = pend_q;
    end

    case (state_q)
      ST_ADDR: if (scl_rise) begin
        shreg_d = {shreg_q[6:0], sda_val};
        if (bit_cnt_q == 3'd0) begin
          bit_cnt_d  = 3'd7;
          rw_d       = sda_val;
          ack_open_d = 1'b0;
          state_d    = (shreg_q[6:0] == DEV_ADDR) ? ST_ADDR_ACK : ST_WAIT_STOP;
        end else begin
          bit_cnt_d = bit_cnt_q - 3'd1;
        end
      end
      ST_ADDR_ACK: begin
        if (scl_fall) begin
          sched = 1'b1;
          if (!ack_open_q) begin
            ack_open_d = 1'b1;
            sched_val  = 1'b1;
          end else begin
            ack_open_d = 1'b0;
            bit_cnt_d  = 3'd7;
            if (rw_q == I2C_READ) begin
              state_d   = ST_READ;
              shreg_d   = bus.tx_data;
              sched_val = ~bus.tx_data[7];
            end else begin
              state_d = ST_WRITE;
            end
          end
        end else if (scl_rise && ack_open_q) begin
          addressed_d = 1'b1;
          tx_req_d    = (rw_q == I2C_READ);
        end
      end
      ST_WRITE: if (scl_rise) begin
        shreg_d = {shreg_q[6:0], sda_val};
        if (bit_cnt_q == 3'd0) begin
          bit_cnt_d  = 3'd7;
          rx_data_d  = {shreg_q[6:0], sda_val};
          rx_valid_d = 1'b1;
          rdy_d      = bus.rx_ready;
          ack_open_d = 1'b0;
          state_d    = ST_WRITE_ACK;
        end else begin
          bit_cnt_d = bit_cnt_q - 3'd1;
        end
      end
      ST_WRITE_ACK: if (scl_fall) begin
        sched = 1'b1;
        if (!ack_open_q) begin
          ack_open_d = 1'b1;
          sched_val  = rdy_q;
        end else begin
          ack_open_d = 1'b0;
          state_d    = ST_WRITE;
        end
      end
      // A load is pending after a master ACK: the next fall opens the byte.
      ST_READ: if (scl_fall) begin
        sched = 1'b1;
        if (load_q) begin
          load_d    = 1'b0;
          bit_cnt_d = 3'd7;
          shreg_d   = bus.tx_data;
          sched_val = ~bus.tx_data[7];
        end else if (bit_cnt_q == 3'd0) begin
          bit_cnt_d = 3'd7;
          state_d   = ST_READ_ACK;
        end else begin
          bit_cnt_d = bit_cnt_q - 3'd1;
          shreg_d   = {shreg_q[6:0], 1'b0};
          sched_val = ~shreg_q[6];
        end
      end
      ST_READ_ACK: if (scl_rise) begin
        if (sda_val == ACK) begin
          tx_req_d = 1'b1;
          load_d   = 1'b1;
          state_d  = ST_READ;
        end else begin
          addressed_d = 1'b0;
          state_d     = ST_WAIT_STOP;
        end
      end
      default: ;
    endcase

    if (sched) begin
      pend_d = sched_val;
      hold_d = HW'(SDA_HOLD);
    end

    if (start_det || stop_det) begin
      state_d     = start_det ? ST_ADDR : ST_IDLE;
      busy_d      = start_det;
      bit_cnt_d   = 3'd7;
      sda_oe_d    = 1'b0;
      hold_d      = '0;
      addressed_d = 1'b0;
      rx_valid_d  = 1'b0;
      tx_req_d    = 1'b0;
      load_d      = 1'b0;
      ack_open_d  = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd7;
      shreg_q     <= '0;
      rw_q        <= 1'b0;
      ack_open_q  <= 1'b0;
      load_q      <= 1'b0;
      rdy_q       <= 1'b0;
      pend_q      <= 1'b0;
      hold_q      <= '0;
      sda_oe_q    <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      addressed_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      rw_q        <= rw_d;
      ack_open_q  <= ack_open_d;
      load_q      <= load_d;
      rdy_q       <= rdy_d;
      pend_q      <= pend_d;
      hold_q      <= hold_d;
      sda_oe_q    <= sda_oe_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_req_q    <= tx_req_d;
      addressed_q <= addressed_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.sda_oe    = sda_oe_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.tx_req    = tx_req_q;
  assign bus.addressed = addressed_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_i2c_subordinate.sv
// Self-checking bench: bus-level I2C master driving the subordinate, with a
// transaction-level expectation model (address match, byte streams, ACKs).
module tb_i2c_subordinate;
  import i2c_pkg::*;

  localparam logic [6:0] OWN = 7'h01;
  localparam int Q = 8;  // clk cycles per quarter SCL period

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  logic rdy = 1'b1;
  logic [7:0] tx_byte = 8'h00;

  always #5 clk = ~clk;

  i2c_subordinate_if bus ();

  assign bus.scl_in   = m_scl;
  assign bus.sda_in   = m_sda & ~bus.sda_oe;
  assign bus.rx_ready = rdy;
  assign bus.tx_data  = tx_byte;

  i2c_subordinate #(.DEV_ADDR(OWN), .SDA_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  int tx_req_cnt = 0;
  int overlap_cnt = 0;
  int oe_cnt = 0;
  logic last_oe;

  logic [7:0] wdat[4];
  logic       wrdy[4];
  logic [7:0] rdat[4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Local-logic side: collect received bytes, answer tx_req with the next byte.
  always @(negedge clk) begin
    if (bus.rx_valid) rx_q.push_back(bus.rx_data);
    if (bus.tx_req) begin
      tx_req_cnt++;
      tx_byte = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hFF;
    end
    if (bus.rx_valid && bus.tx_req) overlap_cnt++;
    if (bus.sda_oe) oe_cnt++;
  end

  initial begin
    #900us;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic start_c();
    m_sda = 1'b1; wq();
    m_scl = 1'b1; wq();
    m_sda = 1'b0; wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic stop_c(output int cyc);
    m_sda = 1'b0; wq();
    m_scl = 1'b1; wq();
    m_sda = 1'b1;
    cyc = 99;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (!bus.busy && cyc == 99) cyc = i;
    end
    wq();
  endtask

  task automatic wbit(input logic b);
    m_sda = b; wq();
    m_scl = 1'b1; wq();
    last_oe = bus.sda_oe; wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic rbit(output logic b);
    m_sda = 1'b1; wq();
    m_scl = 1'b1; wq();
    b = bus.sda_in; wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(ack);
  endtask

  task automatic rbyte(output logic [7:0] d, input logic ack);
    for (int i = 7; i >= 0; i--) rbit(d[i]);
    wbit(ack);
  endtask

  task automatic do_write(input logic [6:0] a, input int n);
    logic ack;
    int cyc;
    int oe0;
    bit hit;
    hit = (a == OWN);
    oe0 = oe_cnt;
    rx_q.delete();
    start_c();
    chk("wr_busy", bus.busy, 1);
    wbyte({a, I2C_WRITE}, ack);
    chk("wr_addr_ack", ack, hit ? ACK : NACK);
    if (hit) begin
      chk("wr_addressed", bus.addressed, 1);
      for (int k = 0; k < n; k++) begin
        rdy = wrdy[k];
        wbyte(wdat[k], ack);
        chk("wr_data_ack", ack, wrdy[k] ? ACK : NACK);
      end
    end
    stop_c(cyc);
    chk("wr_busy_fall_le4", (cyc <= 4), 1);
    chk("wr_rx_count", rx_q.size(), hit ? n : 0);
    if (hit) begin
      for (int k = 0; k < n && k < rx_q.size(); k++) chk("wr_rx_data", rx_q[k], wdat[k]);
    end else begin
      chk("wr_oe_never", oe_cnt - oe0, 0);
    end
    chk("wr_idle_addressed", bus.addressed, 0);
    chk("wr_idle_busy", bus.busy, 0);
    rx_q.delete();
  endtask

  task automatic do_read(input logic [6:0] a, input int n);
    logic ack;
    logic [7:0] d;
    int cyc;
    int tx0;
    int oe0;
    bit hit;
    hit = (a == OWN);
    tx0 = tx_req_cnt;
    oe0 = oe_cnt;
    tx_q.delete();
    for (int k = 0; k < n; k++) tx_q.push_back(rdat[k]);
    start_c();
    wbyte({a, I2C_READ}, ack);
    chk("rd_addr_ack", ack, hit ? ACK : NACK);
    if (hit) begin
      chk("rd_addressed", bus.addressed, 1);
      for (int k = 0; k < n; k++) begin
        rbyte(d, (k == n - 1) ? NACK : ACK);
        chk("rd_data", d, rdat[k]);
        chk("rd_ack_slot_oe", last_oe, 0);
      end
      chk("rd_addressed_after_nack", bus.addressed, 0);
    end else begin
      chk("rd_oe_never", oe_cnt - oe0, 0);
    end
    stop_c(cyc);
    chk("rd_busy_fall_le4", (cyc <= 4), 1);
    chk("rd_tx_req_count", tx_req_cnt - tx0, hit ? n : 0);
    chk("rd_no_rx_valid", rx_q.size(), 0);
  endtask

  // Address the device for write, send nbits of a data byte, then either STOP
  // or leave SCL low so the next transaction opens with a repeated START.
  task automatic aborted_write(input int nbits, input bit use_stop);
    logic ack;
    int cyc;
    rx_q.delete();
    start_c();
    wbyte({OWN, I2C_WRITE}, ack);
    chk("ab_addr_ack", ack, ACK);
    for (int i = 0; i < nbits; i++) wbit(1'($urandom_range(0, 1)));
    if (use_stop) begin
      stop_c(cyc);
      chk("ab_busy_fall_le4", (cyc <= 4), 1);
      chk("ab_addressed", bus.addressed, 0);
    end
  endtask

  initial begin
    logic ack;
    int cyc;
    int n;
    logic [6:0] a;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sda_oe", bus.sda_oe, 0);
    chk("rst_rx_data", bus.rx_data, 0);
    chk("rst_rx_valid", bus.rx_valid, 0);
    chk("rst_tx_req", bus.tx_req, 0);
    chk("rst_addressed", bus.addressed, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    wdat[0] = 8'hAB; wrdy[0] = 1'b1;
    do_write(OWN, 1);

    rdat[0] = 8'hC3;
    do_read(OWN, 1);

    wdat[0] = 8'h77; wrdy[0] = 1'b1;
    do_write(7'h02, 1);

    rdat[0] = 8'h11; rdat[1] = 8'h22; rdat[2] = 8'h33;
    do_read(OWN, 3);

    wdat[0] = 8'h5A; wrdy[0] = 1'b0;
    do_write(OWN, 1);
    rdy = 1'b1;

    aborted_write(4, 1'b1);
    rdat[0] = 8'h96;
    do_read(OWN, 1);

    aborted_write(4, 1'b0);
    rdat[0] = 8'h3C; rdat[1] = 8'hE1;
    do_read(OWN, 2);

    // Reset while the subordinate is pulling SDA for the address ACK.
    rx_q.delete();
    start_c();
    for (int i = 7; i >= 0; i--) wbit(i == 0 ? I2C_WRITE : OWN[i-1]);
    @(negedge clk);
    chk("rst_mid_pre_oe", bus.sda_oe, 1);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_oe", bus.sda_oe, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    stop_c(cyc);
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_no_rx", rx_q.size(), 0);
    wdat[0] = 8'hC5; wrdy[0] = 1'b1; wdat[1] = 8'h0F; wrdy[1] = 1'b1;
    do_write(OWN, 2);

    for (int t = 0; t < 16; t++) begin
      a = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : OWN;
      n = $urandom_range(1, 3);
      for (int k = 0; k < 4; k++) begin
        wdat[k] = 8'($urandom_range(0, 255));
        wrdy[k] = ($urandom_range(0, 3) != 0);
        rdat[k] = 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 1) == 1) do_read(a, n);
      else do_write(a, n);
      rdy = 1'b1;
    end

    chk("rx_tx_overlap", overlap_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
